// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port SRAM access arbiter (IDLE/ACCESS/DONE), all outputs registered
module sram_arbiter #(
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       p0_req,
  input  logic       p0_we,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p0_wdata,
  output logic       p0_gnt,
  output logic [7:0] p0_rdata,
  output logic       p0_rvalid,
  input  logic       p1_req,
  input  logic       p1_we,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p1_wdata,
  output logic       p1_gnt,
  output logic [7:0] p1_rdata,
  output logic       p1_rvalid,
  output logic       sram_en,
  output logic       sram_we,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_wdata,
  input  logic [7:0] sram_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       win_q, win_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic       en_q, en_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       busy_q, busy_d;
  logic       arb_go;
  logic       arb_win;

  // last_q names the port served most recently; a tie goes to the other one
  assign arb_win = (p0_req && p1_req) ? ((FIXED_PRI != 0) ? 1'b0 : ~last_q) : p1_req;
  assign arb_go  = (state_q != ACCESS) && (p0_req || p1_req);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb_go ? ACCESS : IDLE;
      ACCESS:  state_d = DONE;
      DONE:    state_d = arb_go ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    en_d     = 1'b0;
    win_d    = win_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = (state_d != IDLE);
    // read data is captured as ACCESS ends so rvalid lines up with DONE
    if (state_q == ACCESS && !we_q) begin
      if (win_q) begin
        rvalid_d = 2'b10;
        rdata1_d = sram_rdata;
      end else begin
        rvalid_d = 2'b01;
        rdata0_d = sram_rdata;
      end
    end
    if (arb_go) begin
      win_d  = arb_win;
      last_d = arb_win;
      en_d   = 1'b1;
      if (arb_win) begin
        gnt_d   = 2'b10;
        we_d    = p1_we;
        addr_d  = p1_addr;
        wdata_d = p1_wdata;
      end else begin
        gnt_d   = 2'b01;
        we_d    = p0_we;
        addr_d  = p0_addr;
        wdata_d = p0_wdata;
      end
    end
  end

  assign p0_gnt     = gnt_q[0];
  assign p1_gnt     = gnt_q[1];
  assign p0_rvalid  = rvalid_q[0];
  assign p1_rvalid  = rvalid_q[1];
  assign p0_rdata   = rdata0_q;
  assign p1_rdata   = rdata1_q;
  assign sram_en    = en_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter, round-robin and fixed-priority instances
module tb_sram_arbiter;

  typedef struct {int p; bit we; logic [7:0] a; logic [7:0] d; int due;} gexp_t;
  typedef struct {int p; logic [7:0] d; int due;} rexp_t;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       req_r [2][2];
  logic       we_r [2][2];
  logic [7:0] addr_r [2][2];
  logic [7:0] wdata_r [2][2];
  logic       gnt_w [2][2];
  logic       rvalid_w [2][2];
  logic [7:0] rdata_w [2][2];
  logic       en_w [2];
  logic       swe_w [2];
  logic       busy_w [2];
  logic [7:0] saddr_w [2];
  logic [7:0] swdata_w [2];
  logic [7:0] srdata_w [2];
  logic [7:0] sram_mem [2][256];
  logic [7:0] ref_mem [2][256];
  logic [7:0] last_rd [2][2];

  int    nchk = 0;
  int    nfail = 0;
  int    cyc = 0;
  gexp_t gq [2][$];
  rexp_t rq [2][$];
  bit    hold [2];
  int    bcnt [2];
  int    last [2];
  gexp_t ge;
  rexp_t re;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      sram_arbiter #(.FIXED_PRI(g)) u_dut (
        .clk(clk), .arst_n(arst_n),
        .p0_req(req_r[g][0]), .p0_we(we_r[g][0]), .p0_addr(addr_r[g][0]), .p0_wdata(wdata_r[g][0]),
        .p0_gnt(gnt_w[g][0]), .p0_rdata(rdata_w[g][0]), .p0_rvalid(rvalid_w[g][0]),
        .p1_req(req_r[g][1]), .p1_we(we_r[g][1]), .p1_addr(addr_r[g][1]), .p1_wdata(wdata_r[g][1]),
        .p1_gnt(gnt_w[g][1]), .p1_rdata(rdata_w[g][1]), .p1_rvalid(rvalid_w[g][1]),
        .sram_en(en_w[g]), .sram_we(swe_w[g]), .sram_addr(saddr_w[g]), .sram_wdata(swdata_w[g]),
        .sram_rdata(srdata_w[g]), .busy(busy_w[g])
      );
      assign srdata_w[g] = sram_mem[g][saddr_w[g]];
    end
  endgenerate

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // SRAM device: asynchronous read, write on the clock edge that ends an enabled write
  initial begin
    for (int gi = 0; gi < 2; gi++)
      for (int a = 0; a < 256; a++) sram_mem[gi][a] = 8'(a) ^ 8'hB5;
    forever begin
      @(posedge clk);
      for (int gi = 0; gi < 2; gi++)
        if (en_w[gi] && swe_w[gi]) sram_mem[gi][saddr_w[gi]] <= swdata_w[gi];
    end
  end

  // Reference model: one arbitration per free slot, a slot is blocked for the cycle after a grant
  initial begin
    for (int gi = 0; gi < 2; gi++) begin
      for (int a = 0; a < 256; a++) ref_mem[gi][a] = 8'(a) ^ 8'hB5;
      hold[gi] = 1'b0;
      bcnt[gi] = 0;
      last[gi] = 1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int gi = 0; gi < 2; gi++) begin
        int w;
        if (!arst_n) begin
          gq[gi].delete();
          rq[gi].delete();
          hold[gi] = 1'b0;
          bcnt[gi] = 0;
          last[gi] = 1;
        end else if (!hold[gi] && (req_r[gi][0] || req_r[gi][1])) begin
          if (req_r[gi][0] && req_r[gi][1]) w = (gi == 1) ? 0 : 1 - last[gi];
          else w = req_r[gi][1] ? 1 : 0;
          last[gi] = w;
          gq[gi].push_back('{w, we_r[gi][w], addr_r[gi][w], wdata_r[gi][w], cyc});
          if (we_r[gi][w]) ref_mem[gi][addr_r[gi][w]] = wdata_r[gi][w];
          else rq[gi].push_back('{w, ref_mem[gi][addr_r[gi][w]], cyc + 1});
          hold[gi] = 1'b1;
          bcnt[gi] = 2;
        end else begin
          hold[gi] = 1'b0;
          if (bcnt[gi] > 0) bcnt[gi]--;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues every falling edge
  initial begin
    for (int gi = 0; gi < 2; gi++) begin
      last_rd[gi][0] = 8'h00;
      last_rd[gi][1] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int gi = 0; gi < 2; gi++) begin
        logic [1:0] gv, rv, ev;
        if (!arst_n) begin
          last_rd[gi][0] = 8'h00;
          last_rd[gi][1] = 8'h00;
          continue;
        end
        gv = {gnt_w[gi][1], gnt_w[gi][0]};
        rv = {rvalid_w[gi][1], rvalid_w[gi][0]};
        chk(gv != 2'b11, "gnt_overlap", int'(gv), 0);
        chk(en_w[gi] == (gv != 2'b00), "sram_en_vs_gnt", int'(en_w[gi]), int'(gv != 2'b00));
        chk(busy_w[gi] == (bcnt[gi] > 0), "busy", int'(busy_w[gi]), int'(bcnt[gi] > 0));
        if (gq[gi].size() > 0 && gq[gi][0].due == cyc) begin
          ge = gq[gi].pop_front();
          ev = (ge.p == 1) ? 2'b10 : 2'b01;
          chk(gv == ev, "gnt_port", int'(gv), int'(ev));
          chk(swe_w[gi] == ge.we, "sram_we", int'(swe_w[gi]), int'(ge.we));
          chk(saddr_w[gi] == ge.a, "sram_addr", int'(saddr_w[gi]), int'(ge.a));
          if (ge.we) chk(swdata_w[gi] == ge.d, "sram_wdata", int'(swdata_w[gi]), int'(ge.d));
        end else begin
          chk(gv == 2'b00, "gnt_unexpected", int'(gv), 0);
        end
        if (rq[gi].size() > 0 && rq[gi][0].due == cyc) begin
          re = rq[gi].pop_front();
          ev = (re.p == 1) ? 2'b10 : 2'b01;
          chk(rv == ev, "rvalid_port", int'(rv), int'(ev));
          last_rd[gi][re.p] = re.d;
        end else begin
          chk(rv == 2'b00, "rvalid_unexpected", int'(rv), 0);
        end
        for (int p = 0; p < 2; p++)
          chk(rdata_w[gi][p] == last_rd[gi][p], "rdata", int'(rdata_w[gi][p]), int'(last_rd[gi][p]));
      end
    end
  end

  task automatic do_req(input int gi, input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    bit seen;
    we_r[gi][p]    = w;
    addr_r[gi][p]  = a;
    wdata_r[gi][p] = d;
    req_r[gi][p]   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_w[gi][p]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "gnt_timeout", int'(seen), 1);
    req_r[gi][p]   = 1'b0;
    addr_r[gi][p]  = 8'hFF;
    wdata_r[gi][p] = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic run_port(input int gi, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      do_req(gi, p, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
    end
  endtask

  task automatic check_rst(input int gi);
    chk({gnt_w[gi][0], gnt_w[gi][1], rvalid_w[gi][0], rvalid_w[gi][1], en_w[gi], swe_w[gi], busy_w[gi]} == 7'd0,
        "reset_ctrl", int'({gnt_w[gi][0], gnt_w[gi][1], rvalid_w[gi][0], rvalid_w[gi][1], en_w[gi], swe_w[gi], busy_w[gi]}), 0);
    chk(saddr_w[gi] == 8'h00, "reset_sram_addr", int'(saddr_w[gi]), 0);
    chk(swdata_w[gi] == 8'h00, "reset_sram_wdata", int'(swdata_w[gi]), 0);
    chk(rdata_w[gi][0] == 8'h00, "reset_p0_rdata", int'(rdata_w[gi][0]), 0);
    chk(rdata_w[gi][1] == 8'h00, "reset_p1_rdata", int'(rdata_w[gi][1]), 0);
  endtask

  initial begin
    arst_n = 1'b1;
    for (int gi = 0; gi < 2; gi++)
      for (int p = 0; p < 2; p++) begin
        req_r[gi][p] = 1'b0;
        we_r[gi][p] = 1'b0;
        addr_r[gi][p] = 8'h00;
        wdata_r[gi][p] = 8'h00;
      end
    #1 arst_n = 1'b0;
    #3;
    check_rst(0);
    check_rst(1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // simultaneous continuous requests from reset: tie behaviour of both instances
    fork
      begin repeat (4) do_req(0, 0, 1'b0, 8'($urandom_range(15, 0)), 8'h00); end
      begin repeat (4) do_req(0, 1, 1'b0, 8'($urandom_range(15, 0)), 8'h00); end
      begin repeat (3) do_req(1, 0, 1'b0, 8'($urandom_range(15, 0)), 8'h00); end
      begin repeat (3) do_req(1, 1, 1'b0, 8'($urandom_range(15, 0)), 8'h00); end
    join

    // directed read 0x10, write 0x3F <- 0x5A, read-back of 0x3F
    fork
      begin
        do_req(0, 0, 1'b0, 8'h10, 8'h00);
        do_req(0, 1, 1'b1, 8'h3F, 8'h5A);
        do_req(0, 0, 1'b0, 8'h3F, 8'h00);
      end
      begin
        do_req(1, 0, 1'b0, 8'h10, 8'h00);
        do_req(1, 1, 1'b1, 8'h3F, 8'h5A);
        do_req(1, 0, 1'b0, 8'h3F, 8'h00);
      end
    join
    repeat (2) @(negedge clk);

    // reset in the middle of an ACCESS cycle
    for (int gi = 0; gi < 2; gi++) begin
      we_r[gi][0] = 1'b0;
      addr_r[gi][0] = 8'h20;
      req_r[gi][0] = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt_w[0][0]) break;
    end
    chk(gnt_w[0][0] && gnt_w[1][0], "pre_reset_gnt", int'({gnt_w[1][0], gnt_w[0][0]}), 3);
    #2 arst_n = 1'b0;
    for (int gi = 0; gi < 2; gi++) begin
      req_r[gi][0] = 1'b0;
      req_r[gi][1] = 1'b0;
    end
    #1;
    check_rst(0);
    check_rst(1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    fork
      do_req(0, 1, 1'b0, 8'h21, 8'h00);
      do_req(1, 1, 1'b0, 8'h22, 8'h00);
    join

    fork
      run_port(0, 0, 30);
      run_port(0, 1, 30);
      run_port(1, 0, 30);
      run_port(1, 1, 30);
    join
    repeat (6) @(negedge clk);
    for (int gi = 0; gi < 2; gi++)
      chk(gq[gi].size() == 0 && rq[gi].size() == 0, "scoreboard_drained",
          gq[gi].size() + rq[gi].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter FIXED_PRI, default 0, meaning: 0 = round-robin between ports, 1 = port 0 always wins a tie.
REQ-002 Port clk  input  1  rising-edge clock for all sequential logic.
REQ-003 Port arst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port p0_req  input  1  port 0 (control unit) access request, held high until p0_gnt is seen.
REQ-005 Port p0_we  input  1  port 0 write enable: 1 = write, 0 = read.
REQ-006 Port p0_addr  input  8  port 0 SRAM address.
REQ-007 Port p0_wdata  input  8  port 0 write data.
REQ-008 Port p0_gnt  output  1  one-cycle pulse: port 0 request accepted and access issued.
REQ-009 Port p0_rdata  output  8  port 0 read data, valid when p0_rvalid=1.
REQ-010 Port p0_rvalid  output  1  one-cycle pulse: p0_rdata holds read result.
REQ-011 Ports p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid: port 1 (debug/DMA), same directions, widths and meanings as the port 0 signals.
REQ-012 Port sram_en  output  1  SRAM access strobe.
REQ-013 Port sram_we  output  1  SRAM write enable, valid only when sram_en=1.
REQ-014 Port sram_addr  output  8  SRAM address.
REQ-015 Port sram_wdata  output  8  SRAM write data.
REQ-016 Port sram_rdata  input  8  SRAM read data, valid one cycle after an sram_en read.
REQ-017 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; all outputs SHALL be registered.
REQ-019 Arbitration SHALL be evaluated in IDLE and in DONE.
  - If any req is high: latch winner id, we, addr and wdata; go to ACCESS.
  - Otherwise: go to (or stay in) IDLE.
REQ-020 In ACCESS:
  - sram_en=1; sram_we, sram_addr and sram_wdata driven from the latched values.
  - Winner's gnt=1 for exactly this cycle.
  - Next state: DONE.
REQ-021 In DONE with a latched read: winner's rdata <= sram_rdata and rvalid=1 for exactly one cycle. With a latched write: no rvalid.
REQ-022 Single-port request: only that port wins.
REQ-023 Tie with FIXED_PRI=0: the port not served last wins; the last-served pointer SHALL reset to port 1, so port 0 wins the first tie.
REQ-024 Tie with FIXED_PRI=1: port 0 wins every tie.
REQ-025 The last-served pointer SHALL update when a winner is latched.
REQ-026 Latched fields SHALL be unaffected by req, addr or data changes after latching; a req dropped during ACCESS or DONE does not cancel the access.
REQ-027 Latency: req high in IDLE at edge N -> gnt at cycle N+1 -> rvalid at cycle N+2.
REQ-028 Throughput: back-to-back accesses every 2 cycles (ACCESS/DONE alternate while requests are pending).
REQ-029 A requester SHALL deassert req the cycle after gnt; req high in DONE is treated as a new request.
REQ-030 sram_en SHALL be 0 in IDLE and DONE; p0_gnt and p1_gnt SHALL never be high in the same cycle.
REQ-031 p0_rdata and p1_rdata SHALL hold their last value until the next rvalid for that port.

Reset
REQ-032 Reset SHALL asynchronously force:
  - state = IDLE; last-served pointer = port 1.
  - All gnt, rvalid, sram_en, sram_we and busy = 0.
  - sram_addr, sram_wdata, p0_rdata and p1_rdata = 8'h00.
REQ-033 Reset asserted during ACCESS or DONE SHALL abort the transaction with no rvalid; arbitration resumes from IDLE after release.

Verification
REQ-034 p0 read addr 8'h10, SRAM model returns 8'hA5 -> p0_gnt at N+1 with sram_addr=8'h10, sram_we=0; p0_rvalid at N+2 with p0_rdata=8'hA5.
REQ-035 p1 write addr 8'h3F, data 8'h5A -> p1_gnt with sram_en=1, sram_we=1, sram_wdata=8'h5A; no p1_rvalid; a subsequent read of 8'h3F returns 8'h5A.
REQ-036 FIXED_PRI=0, both ports continuously re-request reads -> grant order p0, p1, p0, p1; gnt every 2 cycles; gnts never overlap.
REQ-037 FIXED_PRI=1, both request simultaneously -> p0 granted first, p1 granted on the next arbitration.
REQ-038 p0 read issued, p0_addr changed to 8'hFF and p0_req dropped during ACCESS -> sram_addr stays at the latched value; rvalid still occurs.
REQ-039 arst_n pulled low during ACCESS -> outputs immediately at reset values; no rvalid; after release, a new p1 request is granted in 1 cycle.
